// File: rtl/clk_sample_measure.sv
// Gated edge counter: measures clk_sample_in against clk_in over 2^GATE_LOG2 cycles and
// returns the equivalent phase-accumulator increment.
module clk_sample_measure #(
   parameter int PHASE_WIDTH = 32,
   parameter int GATE_LOG2   = 12
) (
   input  logic                   clk_in,
   input  logic                   RST_n,
   input  logic                   clk_sample_in,
   input  logic                   start,
   input  logic                   cont,
   output logic [PHASE_WIDTH-1:0] sample_fre,
   output logic                   fre_valid,
   output logic                   no_clk,
   output logic                   busy
);

   localparam int SHIFT = PHASE_WIDTH - GATE_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [GATE_LOG2-1:0]   timer_q, timer_d;
   logic [GATE_LOG2-1:0]   count_q, count_d;
   logic                   timeout_q, timeout_d;
   logic [2:0]             sync_q, sync_d;
   logic [PHASE_WIDTH-1:0] fre_q, fre_d;
   logic                   no_clk_q, no_clk_d;
   logic                   edge_det;
   logic                   timer_last;

   // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is its delayed copy for edge detect.
   always_comb begin
      sync_d = {sync_q[1:0], clk_sample_in};
   end

   assign edge_det   = sync_q[1] & ~sync_q[2];
   assign timer_last = &timer_q;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      count_d   = count_q;
      timeout_d = timeout_q;
      fre_d     = fre_q;
      no_clk_d  = no_clk_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start | cont) begin
               state_d   = ST_ARM;
               timer_d   = '0;
               timeout_d = 1'b0;
            end
         end
         // The aligning edge starts the gate but is not itself counted.
         ST_ARM: begin
            if (edge_det) begin
               state_d = ST_GATE;
               timer_d = '0;
               count_d = '0;
            end else if (timer_last) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               fre_d     = '0;
               no_clk_d  = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_GATE: begin
            count_d = count_q + GATE_LOG2'(edge_det);
            if (timer_last) begin
               state_d  = ST_DONE;
               fre_d    = PHASE_WIDTH'(count_d) << SHIFT;
               no_clk_d = 1'b0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            timer_d   = '0;
            timeout_d = 1'b0;
            state_d   = cont ? ST_ARM : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!RST_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         count_q   <= '0;
         timeout_q <= 1'b0;
         sync_q    <= '0;
         fre_q     <= '0;
         no_clk_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         sync_q    <= sync_d;
         fre_q     <= fre_d;
         no_clk_q  <= no_clk_d;
      end
   end

   // Result registers load on entry to DONE, so they are already new while fre_valid is high.
   assign sample_fre = fre_q;
   assign no_clk     = no_clk_q;
   assign fre_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_sample_measure.sv
// Directed bench for clk_sample_measure: a clk_in-driven phase-accumulator generator feeds the
// measured clock; a second small instance covers the GATE_LOG2=4 / PHASE_WIDTH=8 configuration.
module tb_clk_sample_measure;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, cont;
   logic        clk_sample;
   logic [31:0] sample_fre;
   logic        fre_valid, no_clk, busy;

   logic        s_start;
   logic        s_sample = 1'b0;
   logic [7:0]  s_fre;
   logic        s_valid, s_no_clk, s_busy;

   logic        gen_en = 1'b0;
   logic [31:0] gen_inc = 32'h0;
   logic [31:0] gen_acc = 32'h0;
   logic [1:0]  s_cnt = 2'd0;

   int n_cmp = 0;
   int n_bad = 0;
   int vcount = 0;

   always #5 clk = ~clk;

   clk_sample_measure #(.PHASE_WIDTH(32), .GATE_LOG2(12)) u_dut (
      .clk_in(clk), .RST_n(rst_n), .clk_sample_in(clk_sample), .start(start), .cont(cont),
      .sample_fre(sample_fre), .fre_valid(fre_valid), .no_clk(no_clk), .busy(busy)
   );

   clk_sample_measure #(.PHASE_WIDTH(8), .GATE_LOG2(4)) u_small (
      .clk_in(clk), .RST_n(rst_n), .clk_sample_in(s_sample), .start(s_start), .cont(1'b0),
      .sample_fre(s_fre), .fre_valid(s_valid), .no_clk(s_no_clk), .busy(s_busy)
   );

   // Generator model: phase accumulator stepped once per clk_in, MSB is the sample clock.
   always @(negedge clk) begin
      if (gen_en) gen_acc = gen_acc + gen_inc;
      s_cnt    = s_cnt + 2'd1;
      s_sample = s_cnt[1];
   end
   assign clk_sample = gen_en & gen_acc[31];

   always @(negedge clk) if (fre_valid) vcount++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int cycles, output logic hit);
      cycles = 0;
      hit    = 1'b0;
      while (!hit && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (fre_valid) hit = 1'b1;
      end
   endtask

   initial begin
      int   cyc;
      logic hit;
      int   v0;

      rst_n = 1'b0; start = 1'b0; cont = 1'b0; s_start = 1'b0;
      repeat (5) @(negedge clk);
      check_val("rst_sample_fre", sample_fre, 32'h0);
      check_val("rst_fre_valid", {31'b0, fre_valid}, 32'h0);
      check_val("rst_no_clk", {31'b0, no_clk}, 32'h0);
      check_val("rst_busy", {31'b0, busy}, 32'h0);
      rst_n = 1'b1;

      // Loopback at clk_in/16: 256 edges in the gate
      gen_inc = 32'h1000_0000; gen_en = 1'b1;
      repeat (40) @(negedge clk);
      v0 = vcount;
      pulse_start();
      check_val("t1_busy_after_start", {31'b0, busy}, 32'h1);
      wait_valid(10000, cyc, hit);
      check_val("t1_valid_seen", {31'b0, hit}, 32'h1);
      check_val("t1_sample_fre", sample_fre, 32'h1000_0000);
      check_val("t1_no_clk", {31'b0, no_clk}, 32'h0);
      @(negedge clk);
      check_val("t1_idle_after", {31'b0, busy}, 32'h0);
      repeat (200) @(negedge clk);
      check_val("t1_single_valid", vcount - v0, 32'd1);

      // Continuous mode at clk_in/32: steady-state spacing is gate plus one sample period
      gen_inc = 32'h0800_0000;
      cont = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_valid(10000, cyc, hit);
         check_val($sformatf("t2_valid_seen_%0d", r), {31'b0, hit}, 32'h1);
         check_val($sformatf("t2_sample_fre_%0d", r), sample_fre, 32'h0800_0000);
         if (r > 0) check_val($sformatf("t2_spacing_%0d", r), cyc, 32'd4128);
      end
      repeat (100) @(negedge clk);
      cont = 1'b0;
      wait_valid(10000, cyc, hit);
      check_val("t2_last_valid_seen", {31'b0, hit}, 32'h1);
      check_val("t2_last_sample_fre", sample_fre, 32'h0800_0000);
      @(negedge clk);
      check_val("t2_idle_after_cont_drop", {31'b0, busy}, 32'h0);
      v0 = vcount;
      repeat (5000) @(negedge clk);
      check_val("t2_no_extra_valid", vcount - v0, 32'd0);

      // Static input: timeout exactly 4096 cycles after ARM entry
      gen_en = 1'b0;
      repeat (10) @(negedge clk);
      pulse_start();
      wait_valid(10000, cyc, hit);
      check_val("t3_timeout_cycles", cyc, 32'd4096);
      check_val("t3_sample_fre", sample_fre, 32'h0);
      check_val("t3_no_clk", {31'b0, no_clk}, 32'h1);
      gen_inc = 32'h1000_0000; gen_en = 1'b1;
      repeat (40) @(negedge clk);
      pulse_start();
      wait_valid(10000, cyc, hit);
      check_val("t3_recover_seen", {31'b0, hit}, 32'h1);
      check_val("t3_recover_fre", sample_fre, 32'h1000_0000);
      check_val("t3_recover_no_clk", {31'b0, no_clk}, 32'h0);

      // Nyquist: clk_in/2 gives count 2048 with no wrap
      gen_inc = 32'h8000_0000;
      repeat (40) @(negedge clk);
      pulse_start();
      wait_valid(10000, cyc, hit);
      check_val("t4_valid_seen", {31'b0, hit}, 32'h1);
      check_val("t4_sample_fre", sample_fre, 32'h8000_0000);
      check_val("t4_no_clk", {31'b0, no_clk}, 32'h0);

      // Reset mid-gate aborts the run
      gen_inc = 32'h1000_0000;
      repeat (40) @(negedge clk);
      v0 = vcount;
      pulse_start();
      repeat (1000) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("t5_rst_sample_fre", sample_fre, 32'h0);
      check_val("t5_rst_fre_valid", {31'b0, fre_valid}, 32'h0);
      check_val("t5_rst_no_clk", {31'b0, no_clk}, 32'h0);
      check_val("t5_rst_busy", {31'b0, busy}, 32'h0);
      repeat (5000) @(negedge clk);
      check_val("t5_no_valid_after_abort", vcount - v0, 32'd0);
      // start while busy is ignored
      pulse_start();
      repeat (500) @(negedge clk);
      pulse_start();
      wait_valid(10000, cyc, hit);
      check_val("t5_valid_seen", {31'b0, hit}, 32'h1);
      check_val("t5_sample_fre", sample_fre, 32'h1000_0000);
      repeat (5000) @(negedge clk);
      check_val("t5_single_valid", vcount - v0, 32'd1);
      check_val("t5_idle_end", {31'b0, busy}, 32'h0);

      // Small configuration: 16-cycle gate, period-4 input -> 4 edges -> 4 << 4
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (s_valid) hit = 1'b1;
      end
      check_val("t6_valid_seen", {31'b0, hit}, 32'h1);
      check_val("t6_sample_fre", {24'b0, s_fre}, 32'h40);
      check_val("t6_no_clk", {31'b0, s_no_clk}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
